// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, one quotient bit per clock
// Operands and results move through valid/ready handshakes; the MSB of the dividend is resolved first.
module seq_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [DIVIDEND_W-1:0] work_q, work_d;
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  remo_q, remo_d;
  logic                  dbz_q, dbz_d;

  // The partial remainder is always below the divisor, so its extra top bit
  // is implicitly zero and only the shifted trial value needs DIVISOR_W+1 bits.
  logic [DIVISOR_W:0]    trial;
  logic                  trial_ge;
  logic [DIVISOR_W-1:0]  trial_diff;

  assign trial      = {rem_q, work_q[DIVIDEND_W-1]};
  assign trial_ge   = (trial >= {1'b0, dvsr_q});
  assign trial_diff = trial[DIVISOR_W-1:0] - dvsr_q;

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    dvsr_d    = dvsr_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    remo_d    = remo_q;
    dbz_d     = dbz_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d = dividend;
          dvsr_d = divisor;
          rem_d  = '0;
          cnt_d  = CNT_W'(DIVIDEND_W - 1);
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            remo_d  = '0;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Dividend bits shift out at the top while quotient bits shift in at the bottom.
        rem_d  = trial_ge ? trial_diff : trial[DIVISOR_W-1:0];
        work_d = {work_q[DIVIDEND_W-2:0], trial_ge};
        if (cnt_q == '0) begin
          state_d = DONE;
          quot_d  = {work_q[DIVIDEND_W-2:0], trial_ge};
          remo_d  = trial_ge ? trial_diff : trial[DIVISOR_W-1:0];
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      dvsr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dvsr_q  <= dvsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and sweep checks for seq_divider
module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  bit sweep_on = 0;

  seq_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sweep_on && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish, tests=%0d", n_tests);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_div(input logic [7:0] a, input logic [3:0] b, input bit noisy, output int lat);
    int guard;
    guard     = 0;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check_eq("in_ready_before_accept", in_ready, 1);
    tick();
    lat      = 1;
    in_valid = noisy;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    while (!out_valid && lat < 50) begin
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
      end
      tick();
      lat++;
    end
  endtask

  task automatic check_res(input string tag, input int lat, input int exp_lat,
                           input int exp_q, input int exp_r, input int exp_z);
    check_eq($sformatf("%s latency", tag), lat, exp_lat);
    check_eq($sformatf("%s out_valid", tag), out_valid, 1);
    check_eq($sformatf("%s quotient", tag), quotient, exp_q);
    check_eq($sformatf("%s remainder", tag), remainder, exp_r);
    check_eq($sformatf("%s div_by_zero", tag), div_by_zero, exp_z);
  endtask

  task automatic release_out(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq($sformatf("%s in_ready_after_hs", tag), in_ready, 1);
    check_eq($sformatf("%s out_valid_after_hs", tag), out_valid, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq($sformatf("%s in_ready", tag), in_ready, 1);
    check_eq($sformatf("%s out_valid", tag), out_valid, 0);
    check_eq($sformatf("%s quotient", tag), quotient, 0);
    check_eq($sformatf("%s remainder", tag), remainder, 0);
    check_eq($sformatf("%s div_by_zero", tag), div_by_zero, 0);
  endtask

  initial begin
    int lat;
    int hs_guard;
    bit go;
    int eq, er, ez, el;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();
    check_reset_vals("post_reset");

    do_div(8'd200, 4'd7, 1'b0, lat);
    check_res("200/7", lat, 9, 28, 4, 0);
    release_out("200/7");

    do_div(8'd255, 4'd1, 1'b0, lat);
    check_res("255/1", lat, 9, 255, 0, 0);
    release_out("255/1");

    do_div(8'd3, 4'd15, 1'b0, lat);
    check_res("3/15", lat, 9, 0, 3, 0);
    release_out("3/15");

    do_div(8'd0, 4'd9, 1'b0, lat);
    check_res("0/9", lat, 9, 0, 0, 0);
    release_out("0/9");

    do_div(8'd5, 4'd0, 1'b0, lat);
    check_res("5/0", lat, 1, 255, 0, 1);
    release_out("5/0");

    do_div(8'd10, 4'd3, 1'b0, lat);
    check_res("10/3", lat, 9, 3, 1, 0);
    release_out("10/3");

    // Backpressure with stray in_valid pulses while busy
    do_div(8'd100, 4'd9, 1'b1, lat);
    check_res("100/9", lat, 9, 11, 1, 0);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      tick();
      check_eq("bp out_valid", out_valid, 1);
      check_eq("bp quotient", quotient, 11);
      check_eq("bp remainder", remainder, 1);
      check_eq("bp in_ready", in_ready, 0);
    end
    release_out("100/9");

    // Abort mid-calculation
    dividend = 8'd200; divisor = 4'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1 check_reset_vals("mid_calc_reset");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("no_pulse_after_abort", out_valid, 0);
    end
    do_div(8'd50, 4'd6, 1'b0, lat);
    check_res("50/6", lat, 9, 8, 2, 0);
    release_out("50/6");

    // Full operand sweep with random gaps and output stalls
    sweep_on = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        repeat ($urandom_range(0, 1)) tick();
        do_div(8'(a), 4'(b), 1'b0, lat);
        if (b == 0) begin
          el = 1; eq = 255; er = 0; ez = 1;
        end else begin
          el = 9; eq = a / b; er = a % b; ez = 0;
        end
        check_res($sformatf("%0d/%0d", a, b), lat, el, eq, er, ez);
        hs_guard = 0;
        do begin
          out_ready = (hs_guard >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
          go = out_ready;
          tick();
          hs_guard++;
        end while (!go);
        out_ready = 1'b0;
        check_eq("sweep in_ready_after_hs", in_ready, 1);
      end
    end
    tick();
    sweep_on = 1'b0;
    tick();
    check_eq("sweep handshake count", hs_cnt, 4096);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
